// File: rtl/fifo_wptr_full_if.sv
// Write-side bus of the async FIFO write controller.
// Optional almost_full signal exists only when FIFO_ALMOST_FULL_EN is defined.
// master: the write controller itself; slave: the write-domain client/environment.
interface fifo_wptr_full_if #(
    parameter int unsigned addr_size = 4
);
    logic                 w_inc;
    logic [addr_size:0]   rptr_gray_async;
    logic                 we_s;
    logic [addr_size-1:0] addr_w;
    logic [addr_size:0]   wptr_gray;
    logic                 full;
    logic [addr_size:0]   wlevel;
    logic                 overflow;
`ifdef FIFO_ALMOST_FULL_EN
    logic                 almost_full;

    modport master (
        input  w_inc, rptr_gray_async,
        output we_s, addr_w, wptr_gray, full, wlevel, overflow, almost_full
    );

    modport slave (
        output w_inc, rptr_gray_async,
        input  we_s, addr_w, wptr_gray, full, wlevel, overflow, almost_full
    );
`else
    modport master (
        input  w_inc, rptr_gray_async,
        output we_s, addr_w, wptr_gray, full, wlevel, overflow
    );

    modport slave (
        output w_inc, rptr_gray_async,
        input  we_s, addr_w, wptr_gray, full, wlevel, overflow
    );
`endif
endinterface

// File: rtl/fifo_wptr_full.sv
// Write-side controller of the async FIFO: write enable/address for the
// memory, binary/Gray write pointer, 2-flop read-pointer synchronizer,
// registered full, write-side level and sticky overflow.
// Optional registered almost_full when FIFO_ALMOST_FULL_EN is defined.
module fifo_wptr_full #(
    parameter int unsigned addr_size = 4
`ifdef FIFO_ALMOST_FULL_EN
    , parameter int unsigned af_level = 2**addr_size - 2
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fifo_wptr_full_if.master        bus
);

    logic [addr_size:0] wbin_q, wbin_d;
    logic [addr_size:0] wgray_q, wgray_d;
    logic [addr_size:0] rq1_q, rq2_q;
    logic [addr_size:0] rbin_s;
    logic               full_q, full_d;
    logic               ovf_q, ovf_d;
    logic               we;

    // Accept rule, next pointer values, full and overflow next-state
    always_comb begin
        we      = bus.w_inc & ~full_q;
        wbin_d  = wbin_q + {{addr_size{1'b0}}, we};
        wgray_d = wbin_d ^ (wbin_d >> 1);
        // Full when the next write pointer equals the read pointer with the two top Gray bits inverted
        full_d  = (wgray_d == {~rq2_q[addr_size -: 2], rq2_q[addr_size-2:0]});
        ovf_d   = ovf_q | (bus.w_inc & full_q);
    end

    // Gray-to-binary of the synchronized read pointer: bit i is the XOR of bits addr_size..i
    always_comb begin
        rbin_s = '0;
        for (int unsigned i = 0; i <= addr_size; i++) begin
            rbin_s[i] = ^(rq2_q >> i);
        end
    end

    // Write pointer, full and overflow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
        end
    end

    // Two-flop synchronizer for the read-domain Gray pointer; nothing ahead of rq1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq1_q <= '0;
            rq2_q <= '0;
        end else begin
            rq1_q <= bus.rptr_gray_async;
            rq2_q <= rq1_q;
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    logic [addr_size:0] wlevel_next;
    logic               af_q, af_d;

    // Almost-full threshold on the post-write level
    always_comb begin
        wlevel_next = wbin_d - rbin_s;
        af_d        = (32'(wlevel_next) >= af_level);
    end

    // Almost-full register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            af_q <= 1'b0;
        end else begin
            af_q <= af_d;
        end
    end

    assign bus.almost_full = af_q;
`endif

    assign bus.we_s      = we;
    assign bus.addr_w    = wbin_q[addr_size-1:0];
    assign bus.wptr_gray = wgray_q;
    assign bus.full      = full_q;
    assign bus.wlevel    = wbin_q - rbin_s;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full (addr_size=4): count-based reference model plus
// directed literal checks for reset, fill, drain sync, wrap and mid-burst reset.
module tb_fifo_wptr_full;
    localparam int unsigned AW    = 4;
    localparam int          DEPTH = 16;
    localparam int          AF    = 14;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_wptr_full_if #(.addr_size(AW)) bus ();

`ifdef FIFO_ALMOST_FULL_EN
    fifo_wptr_full #(.addr_size(AW), .af_level(AF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`else
    fifo_wptr_full #(.addr_size(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`endif

    int checks = 0;
    int errors = 0;

    // Stimulus read position (binary count) and reference model state
    int rd_stim = 0;
    int m_wcnt  = 0;  // accepted writes, modulo 32
    int m_r1    = 0;  // read count one edge old
    int m_r2    = 0;  // read count two edges old (what the writer sees)
    bit m_full  = 0;
    bit m_ovf   = 0;
    bit m_af    = 0;

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int nxt_w();
        return (m_wcnt + ((bus.w_inc === 1'b1 && !m_full) ? 1 : 0)) % 32;
    endfunction

    function automatic int lvl(input int w, input int r);
        return (w - r + 32) % 32;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_rptr(input int rb);
        rd_stim = rb;
        bus.rptr_gray_async = (AW+1)'(gray(rb));
    endtask

    // Reference model: count writes, delay the read count by two edges
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wcnt <= 0;
            m_r1   <= 0;
            m_r2   <= 0;
            m_full <= 0;
            m_ovf  <= 0;
            m_af   <= 0;
        end else begin
            m_wcnt <= nxt_w();
            m_full <= (lvl(nxt_w(), m_r2) == DEPTH);
            m_ovf  <= m_ovf | (bus.w_inc === 1'b1 && m_full);
            m_af   <= (lvl(nxt_w(), m_r2) >= AF);
            m_r1   <= rd_stim;
            m_r2   <= m_r1;
        end
    end

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        #2;
        chk("we_s",      32'(bus.we_s),      32'(bus.w_inc & ~m_full));
        chk("addr_w",    32'(bus.addr_w),    m_wcnt % DEPTH);
        chk("wptr_gray", 32'(bus.wptr_gray), gray(m_wcnt));
        chk("full",      32'(bus.full),      32'(m_full));
        chk("wlevel",    32'(bus.wlevel),    lvl(m_wcnt, m_r2));
        chk("overflow",  32'(bus.overflow),  32'(m_ovf));
`ifdef FIFO_ALMOST_FULL_EN
        chk("almost_full", 32'(bus.almost_full), 32'(m_af));
`endif
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        // Reset with a write request pending
        rst_n     = 1'b0;
        bus.w_inc = 1'b1;
        set_rptr(0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_we_s",      32'(bus.we_s),      1);
        chk("rst_addr_w",    32'(bus.addr_w),    0);
        chk("rst_wptr_gray", 32'(bus.wptr_gray), 0);
        chk("rst_full",      32'(bus.full),      0);
        chk("rst_wlevel",    32'(bus.wlevel),    0);
        chk("rst_overflow",  32'(bus.overflow),  0);
        @(negedge clk);
        bus.w_inc = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);

        // Fill 16 entries
        for (int i = 0; i < 16; i++) begin
            bus.w_inc = 1'b1;
            #1;
            chk("fill_addr_w", 32'(bus.addr_w), i);
            chk("fill_we_s",   32'(bus.we_s),   1);
`ifdef FIFO_ALMOST_FULL_EN
            if (i == 13) chk("af_after_13", 32'(bus.almost_full), 0);
            if (i == 14) chk("af_after_14", 32'(bus.almost_full), 1);
`endif
            @(negedge clk);
        end
        // 17th request while full
        #1;
        chk("full_after_16",   32'(bus.full),      1);
        chk("wlevel_full",     32'(bus.wlevel),    16);
        chk("wptr_gray_16",    32'(bus.wptr_gray), 5'b11000);
        chk("we_s_when_full",  32'(bus.we_s),      0);
        chk("ovf_before",      32'(bus.overflow),  0);
        @(negedge clk);
        bus.w_inc = 1'b0;
        #1;
        chk("ovf_after",       32'(bus.overflow),  1);
        chk("addr_w_rejected", 32'(bus.addr_w),    0);
        chk("gray_rejected",   32'(bus.wptr_gray), 5'b11000);

        // Drain sync: one read seen after three edges
        set_rptr(1);
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            #1;
            chk("drain_full", 32'(bus.full), (e < 3) ? 1 : 0);
        end
        chk("drain_wlevel", 32'(bus.wlevel), 15);

        // Wrap: reader at 16, write 16 more
        set_rptr(16);
        repeat (3) @(negedge clk);
        #1;
        chk("wrap_wlevel0", 32'(bus.wlevel), 0);
        chk("wrap_full0",   32'(bus.full),   0);
        for (int i = 0; i < 16; i++) begin
            bus.w_inc = 1'b1;
            #1;
            chk("wrap_addr_w", 32'(bus.addr_w), i);
            if (i == 15) chk("wrap_gray_31", 32'(bus.wptr_gray), 5'b10000);
            @(negedge clk);
        end
        bus.w_inc = 1'b0;
        #1;
        chk("wrap_full",   32'(bus.full),      1);
        chk("wrap_gray_0", 32'(bus.wptr_gray), 0);
        chk("wrap_addr_0", 32'(bus.addr_w),    0);
        chk("wrap_wlevel", 32'(bus.wlevel),    16);

        // Reset in the middle of a burst
        set_rptr(0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.w_inc = 1'b1;
            @(negedge clk);
        end
        #1;
        chk("burst_addr_5", 32'(bus.addr_w), 5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_addr_w",    32'(bus.addr_w),    0);
        chk("midrst_wptr_gray", 32'(bus.wptr_gray), 0);
        chk("midrst_wlevel",    32'(bus.wlevel),    0);
        chk("midrst_full",      32'(bus.full),      0);
        chk("midrst_overflow",  32'(bus.overflow),  0);
        chk("midrst_we_s",      32'(bus.we_s),      1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_addr_w", 32'(bus.addr_w), 0);
        @(negedge clk);
        #1;
        chk("post_rst_addr_1", 32'(bus.addr_w),    1);
        chk("post_rst_gray_1", 32'(bus.wptr_gray), 1);
        bus.w_inc = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
